// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of an asynchronous clock (meas_in) over
// a fixed window of sys_clk cycles, reports the count, and flags it against an
// expected window. Used in the board self-test path; in_range drives an LED.
//
// Optional feature: define FREQ_METER_LOSS_DET_EN to build the loss-of-clock
// watchdog that drives clk_lost. Without it, clk_lost is tied to 0.
//
// Output protocol: freq_valid is a one-cycle strobe with no back-pressure.
// freq_count, overflow and in_range change only in the cycle freq_valid is
// high and hold their value until the next strobe. start is a one-cycle
// request that is only accepted while busy is low; run is a level request.
module clk_freq_meter #(
   parameter int GATE_CYCLES = 50000,
   parameter int CNT_W       = 24,
   parameter int EXP_COUNT   = 10000,
   parameter int TOL         = 50,
   parameter int SYNC_STAGES = 2,
   parameter int LOSS_CYCLES = 64
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             meas_in,
   input  logic             start,
   input  logic             run,
   output logic             busy,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid,
   output logic             in_range,
   output logic             overflow,
   output logic             clk_lost,
   output logic [1:0]       fsm_state
);

   // Reject configurations the front end and gate counter cannot support.
   if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || LOSS_CYCLES < 1) begin : g_bad_cfg
      $error("clk_freq_meter: GATE_CYCLES>=2, SYNC_STAGES>=2, LOSS_CYCLES>=1 required");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_GATE   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // Range limits are evaluated one bit wider than the counter so that
   // EXP_COUNT + TOL cannot wrap; the lower limit clamps at zero.
   localparam int LO_INT = (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0;
   localparam int HI_INT = EXP_COUNT + TOL;
   localparam logic [CNT_W:0] RANGE_LO = (CNT_W + 1)'(LO_INT);
   localparam logic [CNT_W:0] RANGE_HI = (CNT_W + 1)'(HI_INT);

   state_t                  state_q;
   state_t                  state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    sync_dly;
   logic                    rise;
   logic [CNT_W-1:0]        edge_cnt;
   logic                    sat;
   logic [GW-1:0]           gate_cnt;
   logic [CNT_W:0]          cnt_ext;
   logic                    cnt_in_window;

   // ---------------------------------------------------------------------
   // Front end: meas_in is treated as asynchronous data. A flop chain brings
   // it into sys_clk, one extra flop gives the previous level for edge detect.
   // ---------------------------------------------------------------------

   // Synchronizer chain plus delay flop, always running.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q   <= '0;
         sync_dly <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], meas_in};
         sync_dly <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~sync_dly;

   // ---------------------------------------------------------------------
   // Control FSM: IDLE -> ARM -> GATE -> REPORT -> (ARM | IDLE)
   // ---------------------------------------------------------------------

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so a pulse while busy
   // is dropped rather than queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start || run) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            state_d = ST_GATE;
         end
         ST_GATE: begin
            if (gate_cnt == '0) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            state_d = run ? ST_ARM : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign fsm_state = state_q;

   // ---------------------------------------------------------------------
   // Gate window and edge counter
   // ---------------------------------------------------------------------

   // ARM clears the counters; GATE counts rises for exactly GATE_CYCLES
   // cycles, including a rise present on the final cycle. The counter sticks
   // at its maximum and remembers that an edge was lost.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         edge_cnt <= '0;
         sat      <= 1'b0;
         gate_cnt <= '0;
      end else begin
         case (state_q)
            ST_ARM: begin
               edge_cnt <= '0;
               sat      <= 1'b0;
               gate_cnt <= GATE_LOAD;
            end
            ST_GATE: begin
               if (rise) begin
                  if (edge_cnt == CNT_MAX) begin
                     sat <= 1'b1;
                  end else begin
                     edge_cnt <= edge_cnt + 1'b1;
                  end
               end
               if (gate_cnt != '0) begin
                  gate_cnt <= gate_cnt - 1'b1;
               end
            end
            default: begin
               edge_cnt <= edge_cnt;
               sat      <= sat;
               gate_cnt <= gate_cnt;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Result registers
   // ---------------------------------------------------------------------

   assign cnt_ext       = {1'b0, edge_cnt};
   assign cnt_in_window = (cnt_ext >= RANGE_LO) && (cnt_ext <= RANGE_HI);

   // Latch count and flags together at the end of the REPORT cycle so they
   // become visible in the same cycle as the freq_valid strobe.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         freq_count <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
         in_range   <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         if (state_q == ST_REPORT) begin
            freq_count <= edge_cnt;
            freq_valid <= 1'b1;
            overflow   <= sat;
            in_range   <= cnt_in_window && !sat;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Loss-of-clock watchdog
   // ---------------------------------------------------------------------
`ifdef FREQ_METER_LOSS_DET_EN
   localparam int WW = $clog2(LOSS_CYCLES + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(LOSS_CYCLES);

   logic [WW-1:0] wd_cnt;

   // Cycles since the last synchronized rise, saturating at the limit.
   // Runs regardless of FSM state.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wd_cnt <= '0;
      end else if (rise) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign clk_lost = (wd_cnt == WD_LIMIT);
`else
   assign clk_lost = 1'b0;
`endif

endmodule
